// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: requester/FIFO-side bundle for the round-robin burst arbiter
interface fifo_rr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic                     fifo_full;
  logic [N_REQ-1:0]         gnt;
  logic                     push;
  logic [DATA_W-1:0]        push_data;
  logic [$clog2(N_REQ)-1:0] owner;
  logic                     busy;
  modport master (
    input  req, req_data, fifo_full,
    output gnt, push, push_data, owner, busy
  );
  modport slave (
    output req, req_data, fifo_full,
    input  gnt, push, push_data, owner, busy
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin arbiter granting bounded push bursts into a shared FIFO
module fifo_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fifo_rr_arbiter_if.master        bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]   sel;
  logic            found;
  logic [N_REQ-1:0] gnt;
  logic [DATA_W-1:0] push_data;
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  // first requester at or above rr_ptr, wrapping modulo N_REQ
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[IW'((int'(rr_ptr_q) + k) % N_REQ)]) begin
        found = 1'b1;
        sel   = IW'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end
  // grant and next-state decision; reset low suppresses any grant in the same cycle
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt         = '0;
    if (!rst) begin
      gnt = '0;
    end else if (state_q == IDLE) begin
      if (found && !bus.fifo_full) begin
        gnt[sel]    = 1'b1;
        owner_d     = sel;
        burst_cnt_d = 4'd1;
        if (MAX_BURST > 1) state_d = BURST;
        else rr_ptr_d = next_idx(sel);
      end
    end else if (!bus.req[owner_q]) begin
      state_d  = IDLE;
      rr_ptr_d = next_idx(owner_q);
    end else if (!bus.fifo_full) begin
      gnt[owner_q] = 1'b1;
      burst_cnt_d  = burst_cnt_q + 4'd1;
      if (burst_cnt_q + 4'd1 == 4'(MAX_BURST)) begin
        state_d  = IDLE;
        rr_ptr_d = next_idx(owner_q);
      end
    end
  end
  // write-data mux from the one-hot grant, zero when nothing is pushed
  always_comb begin
    push_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[IW'(i)]) push_data = bus.req_data[i*DATA_W +: DATA_W];
  end
  assign bus.gnt       = gnt;
  assign bus.push      = |gnt;
  assign bus.push_data = push_data;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == BURST);
  // arbitration state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed scoreboard bench for the round-robin burst arbiter
module tb_fifo_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] dat [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [7:0] data;
  } exp_t;
  exp_t  sb [$];
  string tq [$];
  fifo_rr_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();
  fifo_rr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] exp_data(input logic [3:0] g);
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < 4; i++) if (g[i]) d = dat[i];
    return d;
  endfunction
  task automatic check();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tq.pop_front();
    tests++;
    assert (bus.gnt === e.gnt) else begin
      fails++;
      $error("FAIL %s gnt: got %b expected %b", t, bus.gnt, e.gnt);
    end
    tests++;
    assert (bus.push === (|e.gnt)) else begin
      fails++;
      $error("FAIL %s push: got %b expected %b", t, bus.push, |e.gnt);
    end
    tests++;
    assert (bus.push_data === e.data) else begin
      fails++;
      $error("FAIL %s push_data: got %h expected %h", t, bus.push_data, e.data);
    end
    tests++;
    assert (bus.busy === e.busy) else begin
      fails++;
      $error("FAIL %s busy: got %b expected %b", t, bus.busy, e.busy);
    end
  endtask
  // called just after a falling edge: drive, queue expectation, sample, move to next falling edge
  task automatic step(input logic [3:0] r, input logic f, input logic [3:0] eg,
                      input logic eb, input string tag);
    exp_t e;
    bus.req       = r;
    bus.fifo_full = f;
    e.gnt  = eg;
    e.busy = eb;
    e.data = exp_data(eg);
    sb.push_back(e);
    tq.push_back(tag);
    #1 check();
    @(negedge clk);
  endtask
  initial begin
    bus.req       = '0;
    bus.fifo_full = 1'b0;
    bus.req_data  = {dat[3], dat[2], dat[1], dat[0]};
    @(negedge clk);
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "rst_hold");
    rst = 1'b1;
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "solo_g1");
    step(4'b0100, 1'b0, 4'b0100, 1'b1, "solo_g2");
    step(4'b0100, 1'b0, 4'b0100, 1'b1, "solo_g3");
    step(4'b0100, 1'b0, 4'b0100, 1'b1, "solo_g4");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "solo_idle_regrant");
    step(4'b0000, 1'b0, 4'b0000, 1'b1, "solo_release");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "solo_idle");
    rst = 1'b0;
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "rst2");
    rst = 1'b1;
    for (int k = 0; k < 16; k++)
      step(4'b1111, 1'b0, 4'(1 << (k / 4)), (k % 4) != 0, $sformatf("rr_%0d", k));
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_wrap");
    step(4'b1111, 1'b0, 4'b0001, 1'b1, "rr_burst2");
    rst = 1'b0;
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "rst_mid_burst");
    rst = 1'b1;
    step(4'b1000, 1'b0, 4'b1000, 1'b0, "post_rst_r3");
    step(4'b0001, 1'b0, 4'b0000, 1'b1, "owner_drop");
    step(4'b0001, 1'b0, 4'b0001, 1'b0, "wrap_to_0");
    step(4'b0000, 1'b0, 4'b0000, 1'b1, "r0_release");
    step(4'b0010, 1'b1, 4'b0000, 1'b0, "idle_full");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "stall_g1");
    step(4'b0010, 1'b0, 4'b0010, 1'b1, "stall_g2");
    for (int k = 0; k < 3; k++)
      step(4'b0010, 1'b1, 4'b0000, 1'b1, $sformatf("stall_full_%0d", k));
    step(4'b0010, 1'b0, 4'b0010, 1'b1, "stall_g3");
    step(4'b0010, 1'b0, 4'b0010, 1'b1, "stall_g4");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "stall_done");
    rst = 1'b0;
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "rst3");
    rst = 1'b1;
    step(4'b1010, 1'b0, 4'b0010, 1'b0, "data_g1");
    step(4'b1010, 1'b0, 4'b0010, 1'b1, "data_g2");
    step(4'b1010, 1'b0, 4'b0010, 1'b1, "data_g3");
    step(4'b1010, 1'b0, 4'b0010, 1'b1, "data_g4");
    step(4'b1010, 1'b0, 4'b1000, 1'b0, "data_r3");
    step(4'b0010, 1'b0, 4'b0000, 1'b1, "data_r3_release");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "data_r1_again");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the width of one FIFO word.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive pushes per grant (1..15).
REQ-004 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester push request; bit i is requester i.
REQ-007 req_data  input  N_REQ*DATA_W  packed write data; slice i is [i*DATA_W +: DATA_W].
REQ-008 fifo_full  input  1  full flag of the shared FIFO.
REQ-009 gnt  output  N_REQ  one-hot grant; the word is accepted in the same cycle as the grant.
REQ-010 push  output  1  push strobe to the FIFO.
REQ-011 push_data  output  DATA_W  write data to the FIFO.
REQ-012 owner  output  clog2(N_REQ)  index of the current or last burst owner.
REQ-013 busy  output  1  high while the state machine is in BURST.

Function
REQ-014 gnt, push and push_data SHALL be combinational from the registered state, req and fifo_full.
REQ-015 push SHALL equal OR-reduce(gnt); push_data SHALL be the req_data slice of the granted index, or 0 when push=0.
REQ-016 gnt SHALL be zero whenever fifo_full=1, so the block never pushes into a full FIFO.
REQ-017 Registered state SHALL be: state {IDLE, BURST}, rr_ptr (clog2(N_REQ) bits), owner, burst_cnt (4 bits).
REQ-018 In IDLE with req!=0 and fifo_full=0, sel SHALL be the first set req bit searching upward from rr_ptr, with modulo-N_REQ wrap; gnt[sel] SHALL be 1.
REQ-019 On an IDLE grant: owner<=sel and burst_cnt<=1; state<=BURST if MAX_BURST>1, else remain IDLE with rr_ptr<=(sel+1) mod N_REQ.
REQ-020 In IDLE with req=0 or fifo_full=1, there SHALL be no grant and no state change.
REQ-021 In BURST with req[owner]=1 and fifo_full=0: gnt[owner]=1 and burst_cnt<=burst_cnt+1.
REQ-022 If that BURST grant makes burst_cnt+1==MAX_BURST, then state<=IDLE and rr_ptr<=(owner+1) mod N_REQ.
REQ-023 In BURST with req[owner]=1 and fifo_full=1, the block SHALL stall with no grant and hold state and burst_cnt unchanged.
REQ-024 In BURST with req[owner]=0, there SHALL be no grant; state<=IDLE and rr_ptr<=(owner+1) mod N_REQ (one release cycle).
REQ-025 Requests from non-owners SHALL be ignored while in BURST.
REQ-026 No requester SHALL receive more than MAX_BURST consecutive pushes.
REQ-027 With all requesters continuously active and the FIFO never full, grant order SHALL be strictly round-robin.
REQ-028 busy SHALL equal (state==BURST).

Reset
REQ-029 While rst=0: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, and therefore gnt=0, push=0, push_data=0, busy=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately, with no push in that cycle.
REQ-031 After reset release, the first arbitration SHALL start searching from index 0.

Verification
REQ-032 Reset, then req=4'b0100 held with FIFO not full: gnt=4'b0100 for exactly 4 cycles, then 1 IDLE cycle; next grant is to requester 2 again with rr_ptr=3.
REQ-033 req=4'b1111 held, never full: owner sequence 0,0,0,0,1,1,1,1,2,...,3, then wraps to 0; 16 pushes in 16 cycles.
REQ-034 Requester 1 bursting, fifo_full=1 after 2 pushes for 3 cycles: gnt=0 for those 3 cycles, busy=1, then exactly 2 more pushes before release.
REQ-035 Requester 3 owner, req[3] drops after 1 push while req[0]=1: one cycle with no grant, then gnt=4'b0001 (wrap from rr_ptr=0).
REQ-036 push_data check: req_data slices 0xA0..0xA3, req=4'b1010: first push_data=0xA1, then after release push_data=0xA3.
REQ-037 rst asserted during burst cycle 2: gnt=0 and busy=0 immediately; after release, req=4'b1000 is granted from the search start at index 0.
